div_seq: RTL



---
 rtl/div_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// data_rdy/result_rdy handshake. Optional feature macro: DIV_ZERO_CHECK_EN.
module div_seq #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         result_rdy,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  dvd;
  logic [N-1:0]  quo;
  logic [N-1:0]  quo_next;
  logic [M-1:0]  dsr;
  logic [M:0]    pr;
  logic [M:0]    pr_shift;
  logic [M:0]    pr_next;
  logic [CW-1:0] cnt;
  logic          ge;
  logic          zero_skip;
  logic          dbz_q;

  assign busy        = (state == CALC);
  assign result_rdy  = (state == DONE);
  assign div_by_zero = dbz_q;

`ifdef DIV_ZERO_CHECK_EN
  assign zero_skip = (dsr == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // One restoring step: the M+1-bit compare cannot overflow since pr < divisor.
  always_comb begin
    pr_shift = {pr[M-1:0], dvd[N-1]};
    ge       = (pr_shift >= {1'b0, dsr});
    pr_next  = ge ? (pr_shift - {1'b0, dsr}) : pr_shift;
    quo_next = {quo[N-2:0], ge};
  end

  // NOTE: only control state and the visible result registers are reset; the
  // datapath registers are always loaded on accept before they are read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      quotient  <= '0;
      remainder <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (data_rdy) begin
            dvd   <= dividend;
            dsr   <= divisor;
            pr    <= '0;
            quo   <= '0;
            cnt   <= CW'(N - 1);
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (zero_skip) begin
            // No step has run yet, so dvd still holds the original dividend.
            state     <= DONE;
            quotient  <= '1;
            remainder <= M'(dvd);
            dbz_q     <= 1'b1;
          end else begin
            pr  <= pr_next;
            dvd <= dvd << 1;
            quo <= quo_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              state     <= DONE;
              quotient  <= quo_next;
              remainder <= pr_next[M-1:0];
              dbz_q     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
